// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g} with a as the MSB; all patterns are
// active-low (0 = segment lit).
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b1111110;

  // Indexed by BCD code; codes 10..15 show a dash (g only).
  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, // 15..10
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/bcd_seven_scan_if.sv
// Host-side bus of the scan driver: packed BCD word, load strobe, blank.
//   bcd_in : 4*NUM_DIGITS packed BCD, digit 0 in the low nibble
//   load   : capture bcd_in this cycle
//   blank  : force the display dark (scanning continues)
// master = the producing datapath, slave = bcd_seven_scan.
interface bcd_seven_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load;
  logic                    blank;

  modport master (output bcd_in, output load, output blank);
  modport slave  (input  bcd_in, input  load, input  blank);
endinterface

// File: rtl/bcd7_decode.sv
// Combinational BCD -> active-low seven-segment lookup.
//   bcd : 4-bit code
//   seg : {a..g}, active-low; codes 10..15 give a dash
module bcd7_decode
  import seg7_pkg::*;
(
  input  bcd_t  bcd,
  output seg7_t seg
);
  assign seg = SEG_LUT[bcd];
endmodule

// File: rtl/bcd_seven_scan.sv
// Time-multiplexed driver for NUM_DIGITS BCD digits on a shared active-low
// seven-segment bus. Loads land in a pending buffer and are promoted to the
// displayed set only at frame wrap, so a frame never tears.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   host        : bcd_seven_scan_if.slave (bcd_in, load, blank)
//   seg         : {a..g} active-low segments
//   dig_an      : one-hot-low digit enables
//   frame_done  : one-cycle pulse after each frame wrap
// Optional: define LEADING_ZERO_BLANK_EN to dark leading zero digits
// (digit 0 always shown).
module bcd_seven_scan
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int SCAN_DIV   = 1000,
  localparam int CNT_W      = $clog2(SCAN_DIV),
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_seven_scan_if.slave       host,
  output seg7_t                 seg,
  output logic [NUM_DIGITS-1:0] dig_an,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;
  logic                    pend_vld;
  logic                    tick;
  logic                    wrap;
  bcd_t                    cur;
  seg7_t                   cur_seg;
  logic                    suppress;

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the wrap cycle bypasses pending and goes live at once,
  // leaving the pending word untouched but invalidated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      pend_vld   <= 1'b0;
      active     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (wrap) begin
        pend_vld <= 1'b0;
        if (host.load)     active <= host.bcd_in;
        else if (pend_vld) active <= pending;
      end else if (host.load) begin
        pending  <= host.bcd_in;
        pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    cur = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) cur = active[4*k +: 4];
    end
  end

  bcd7_decode u_decode (
    .bcd (cur),
    .seg (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // lead_zero[k] is set when digit k and every digit above it are zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      run          = run & (active[4*k +: 4] == 4'd0);
      lead_zero[k] = run;
    end
  end

  assign suppress = lead_zero[idx];
`else
  assign suppress = 1'b0;
`endif

  // First cycle of every slot is dark so the previous digit cannot ghost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_BLANK;
      dig_an <= '1;
    end else if (host.blank || cnt == '0) begin
      seg    <= SEG_BLANK;
      dig_an <= '1;
    end else begin
      seg    <= suppress ? SEG_BLANK : cur_seg;
      dig_an <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule
